// File: rtl/id_fwd_stage.sv
// RV32I decode stage with generalised operand forwarding, load-use stall,
// early branch/jump resolution and an ID/EX output register with flush.
// Optional RV32M decode is enabled by defining RV32M_DECODE_EN.
module id_fwd_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned RA_W       = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_inst,
  output logic                       re1,
  output logic                       re2,
  output logic [RA_W-1:0]            raddr1,
  output logic [RA_W-1:0]            raddr2,
  input  logic [XLEN-1:0]            rdata1,
  input  logic [XLEN-1:0]            rdata2,
  input  logic [FWD_STAGES-1:0]      fwd_we,
  input  logic [FWD_STAGES-1:0]      fwd_pending,
  input  logic [FWD_STAGES*RA_W-1:0] fwd_waddr,
  input  logic [FWD_STAGES*XLEN-1:0] fwd_wdata,
  input  logic                       flush,
  output logic                       br,
  output logic [XLEN-1:0]            br_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_alusel,
  output logic [7:0]                 out_aluop,
  output logic                       out_we,
  output logic [RA_W-1:0]            out_waddr,
  output logic [XLEN-1:0]            out_opv1,
  output logic [XLEN-1:0]            out_opv2,
  output logic [XLEN-1:0]            out_mem_offset,
  output logic [XLEN-1:0]            out_link_addr,
  output logic [XLEN-1:0]            out_rs2_data,
  output logic                       out_illegal
);

  // Result classes; 0 is the NOP class
  localparam logic [2:0] SelNop = 3'd0, SelLogic = 3'd1, SelShift = 3'd2, SelArith = 3'd4,
                         SelMulDiv = 3'd5, SelJump = 3'd6, SelLoadStore = 3'd7;
  // Operations; 0 is the NOP op. Groups are contiguous so funct3 can be added as an offset.
  localparam logic [7:0] OpNop = 8'h00, OpAdd = 8'h01, OpSub = 8'h02, OpSlt = 8'h03,
                         OpSltu = 8'h04, OpXor = 8'h05, OpOr = 8'h06, OpAnd = 8'h07,
                         OpSll = 8'h08, OpSrl = 8'h09, OpSra = 8'h0a, OpJal = 8'h10,
                         OpJalr = 8'h11, OpBr = 8'h18, OpLoad = 8'h20, OpStore = 8'h28;
`ifdef RV32M_DECODE_EN
  localparam logic [7:0] OpMul = 8'h30;
`endif

  logic [6:0] w_opcode, w_f7;
  logic [2:0] w_f3;
  logic [RA_W-1:0] w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_opcode = in_inst[6:0];
  assign w_rd     = RA_W'(in_inst[11:7]);
  assign w_f3     = in_inst[14:12];
  assign w_rs1    = RA_W'(in_inst[19:15]);
  assign w_rs2    = RA_W'(in_inst[24:20]);
  assign w_f7     = in_inst[31:25];
  assign w_imm_i  = XLEN'($signed(in_inst[31:20]));
  assign w_imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign w_imm_b  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign w_imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign w_imm_j  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21],
                                   1'b0}));

  logic w_re1, w_re2, w_we, w_illegal, w_is_br, w_is_jal, w_is_jalr;
  logic [2:0] w_alusel;
  logic [7:0] w_aluop;
  logic [XLEN-1:0] w_imm1, w_imm2, w_mem_off, w_link;

  // Instruction decode; any unmatched encoding collapses to an illegal NOP
  always_comb begin
    w_re1 = 1'b0; w_re2 = 1'b0; w_we = 1'b0; w_illegal = 1'b0;
    w_is_br = 1'b0; w_is_jal = 1'b0; w_is_jalr = 1'b0;
    w_alusel = SelNop; w_aluop = OpNop;
    w_imm1 = '0; w_imm2 = '0; w_mem_off = '0; w_link = '0;
    case (w_opcode)
      7'b0110111: begin  // LUI
        w_we = 1'b1; w_alusel = SelArith; w_aluop = OpAdd; w_imm2 = w_imm_u;
      end
      7'b0010111: begin  // AUIPC
        w_we = 1'b1; w_alusel = SelArith; w_aluop = OpAdd; w_imm1 = in_pc; w_imm2 = w_imm_u;
      end
      7'b1101111: begin  // JAL
        w_we = 1'b1; w_alusel = SelJump; w_aluop = OpJal; w_is_jal = 1'b1;
        w_link = in_pc + XLEN'(4);
      end
      7'b1100111: begin  // JALR
        if (w_f3 != 3'b000) w_illegal = 1'b1;
        w_re1 = 1'b1; w_we = 1'b1; w_alusel = SelJump; w_aluop = OpJalr; w_is_jalr = 1'b1;
        w_link = in_pc + XLEN'(4);
      end
      7'b1100011: begin  // BRANCH
        if (w_f3 == 3'b010 || w_f3 == 3'b011) w_illegal = 1'b1;
        w_re1 = 1'b1; w_re2 = 1'b1; w_alusel = SelJump; w_aluop = OpBr + {5'b0, w_f3};
        w_is_br = 1'b1;
      end
      7'b0000011: begin  // LOAD
        if (w_f3 == 3'b011 || w_f3[2:1] == 2'b11) w_illegal = 1'b1;
        w_re1 = 1'b1; w_we = 1'b1; w_alusel = SelLoadStore; w_aluop = OpLoad + {5'b0, w_f3};
        w_imm2 = w_imm_i; w_mem_off = w_imm_i;
      end
      7'b0100011: begin  // STORE
        if (w_f3[2] || w_f3 == 3'b011) w_illegal = 1'b1;
        w_re1 = 1'b1; w_re2 = 1'b1; w_alusel = SelLoadStore; w_aluop = OpStore + {5'b0, w_f3};
        w_mem_off = w_imm_s;
      end
      7'b0010011, 7'b0110011: begin  // OP-IMM / OP share the funct3 map
        w_re1 = 1'b1; w_we = 1'b1;
        w_re2 = w_opcode[5];
        w_imm2 = w_opcode[5] ? '0 : w_imm_i;
        case (w_f3)
          3'b000: begin
            w_alusel = SelArith;
            w_aluop = (w_opcode[5] && w_f7 == 7'b0100000) ? OpSub : OpAdd;
          end
          3'b010: begin w_alusel = SelArith; w_aluop = OpSlt;  end
          3'b011: begin w_alusel = SelArith; w_aluop = OpSltu; end
          3'b100: begin w_alusel = SelLogic; w_aluop = OpXor;  end
          3'b110: begin w_alusel = SelLogic; w_aluop = OpOr;   end
          3'b111: begin w_alusel = SelLogic; w_aluop = OpAnd;  end
          3'b001: begin w_alusel = SelShift; w_aluop = OpSll;  end
          default: begin w_alusel = SelShift; w_aluop = w_f7[5] ? OpSra : OpSrl; end
        endcase
        // funct7 legality: SUB/SRA only take 0100000; immediates other than shifts are free
        if (w_opcode[5] || w_f3 == 3'b001 || w_f3 == 3'b101) begin
          if (w_f7 == 7'b0000001 && w_opcode[5]) begin
`ifdef RV32M_DECODE_EN
            w_alusel = SelMulDiv; w_aluop = OpMul + {5'b0, w_f3};
`else
            w_illegal = 1'b1;
`endif
          end else if (w_f7 == 7'b0100000) begin
            if (!(w_f3 == 3'b101 || (w_opcode[5] && w_f3 == 3'b000))) w_illegal = 1'b1;
          end else if (w_f7 != 7'b0000000) begin
            w_illegal = 1'b1;
          end
        end
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_re1 = 1'b0; w_re2 = 1'b0; w_we = 1'b0; w_is_br = 1'b0; w_is_jal = 1'b0;
      w_is_jalr = 1'b0; w_alusel = SelNop; w_aluop = OpNop;
      w_imm1 = '0; w_imm2 = '0; w_mem_off = '0; w_link = '0;
    end
  end

  logic [XLEN-1:0] w_src1, w_src2;
  logic w_pend1, w_pend2;

  // Forwarding: scan oldest to youngest so the lowest-index match wins; x0 is never forwarded
  always_comb begin
    w_src1 = rdata1; w_pend1 = 1'b0;
    w_src2 = rdata2; w_pend2 = 1'b0;
    for (int i = int'(FWD_STAGES) - 1; i >= 0; i--) begin
      if (fwd_we[i] && fwd_waddr[i*RA_W +: RA_W] == w_rs1) begin
        w_src1 = fwd_wdata[i*XLEN +: XLEN]; w_pend1 = fwd_pending[i];
      end
      if (fwd_we[i] && fwd_waddr[i*RA_W +: RA_W] == w_rs2) begin
        w_src2 = fwd_wdata[i*XLEN +: XLEN]; w_pend2 = fwd_pending[i];
      end
    end
    if (w_rs1 == '0) begin w_src1 = '0; w_pend1 = 1'b0; end
    if (w_rs2 == '0) begin w_src2 = '0; w_pend2 = 1'b0; end
  end

  logic [XLEN-1:0] w_opv1, w_opv2, w_target;
  logic w_stall, w_accept, w_take;
  logic r_valid;

  assign re1     = w_re1;
  assign re2     = w_re2;
  assign raddr1  = w_re1 ? w_rs1 : '0;
  assign raddr2  = w_re2 ? w_rs2 : '0;
  assign w_opv1  = w_re1 ? w_src1 : w_imm1;
  assign w_opv2  = w_re2 ? w_src2 : w_imm2;
  assign w_stall = in_valid & ((w_re1 & w_pend1) | (w_re2 & w_pend2));
  assign in_ready = !rst && !flush && !w_stall && (!r_valid || out_ready);
  assign w_accept = in_valid & in_ready;

  // Branch condition and redirect target from the resolved operands
  always_comb begin
    w_take   = w_is_jal | w_is_jalr;
    w_target = w_is_jalr ? ((w_opv1 + w_imm_i) & ~XLEN'(1))
             : w_is_jal ? (in_pc + w_imm_j) : (in_pc + w_imm_b);
    if (w_is_br) begin
      case (w_f3)
        3'b000:  w_take = (w_opv1 == w_opv2);
        3'b001:  w_take = (w_opv1 != w_opv2);
        3'b100:  w_take = ($signed(w_opv1) <  $signed(w_opv2));
        3'b101:  w_take = ($signed(w_opv1) >= $signed(w_opv2));
        3'b110:  w_take = (w_opv1 <  w_opv2);
        3'b111:  w_take = (w_opv1 >= w_opv2);
        default: w_take = 1'b0;
      endcase
    end
  end

  assign br      = w_accept & w_take;
  assign br_addr = br ? w_target : '0;

  // ID/EX register: flush beats accept, accept beats drain-on-ready, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0; out_alusel <= SelNop; out_aluop <= OpNop; out_we <= 1'b0;
      out_waddr <= '0; out_opv1 <= '0; out_opv2 <= '0; out_mem_offset <= '0;
      out_link_addr <= '0; out_rs2_data <= '0; out_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1; out_alusel <= w_alusel; out_aluop <= w_aluop; out_we <= w_we;
      out_waddr <= w_we ? w_rd : '0; out_opv1 <= w_opv1; out_opv2 <= w_opv2;
      out_mem_offset <= w_mem_off; out_link_addr <= w_link;
      out_rs2_data <= w_re2 ? w_src2 : '0; out_illegal <= w_illegal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;

endmodule
